// File: rtl/fpga_reset_conditioner.sv
// -----------------------------------------------------------------------------
// fpga_reset_conditioner
//
// Produces the clean active-low chip reset for the FPGA PULPissimo top level
// (drives the SoC pad_reset_n). The raw pushbutton and the clock-manager lock
// are synchronised into clk_i and the button is debounced. Reset is held while
// the button is pressed or the clock is unlocked. Once both are good, release
// is stretched by STRETCH_CYCLES. The reset output comes straight from a flop.
//
// Ports:
//   clk_i         reference clock
//   rst_ni        asynchronous active-low power-on reset
//   btn_reset_i   raw pushbutton, active-high, asynchronous, bouncy
//   clk_locked_i  clock-manager lock, asynchronous, 1 = locked
//   rst_no        conditioned active-low reset to the SoC (registered)
//   rst_active_o  1 while the conditioner is not in RUN
//   press_cnt_o   saturating count of accepted (debounced) button presses
// -----------------------------------------------------------------------------
module fpga_reset_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STRETCH_CYCLES  = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_reset_i,
  input  logic       clk_locked_i,
  output logic       rst_no,
  output logic       rst_active_o,
  output logic [7:0] press_cnt_o
);

  localparam int CNT_MAX   = (DEBOUNCE_CYCLES > STRETCH_CYCLES) ? DEBOUNCE_CYCLES : STRETCH_CYCLES;
  localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ST_LAST = CNT_WIDTH'(STRETCH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   btn_s;
  logic                   lock_s;

  logic                   btn_db_q,   btn_db_d;
  logic [CNT_WIDTH-1:0]   db_cnt_q,   db_cnt_d;
  logic [7:0]             press_cnt_q, press_cnt_d;

  state_e                 state_q,    state_d;
  logic [CNT_WIDTH-1:0]   st_cnt_q,   st_cnt_d;
  logic                   rst_n_q;
  logic                   ok;

  // Input synchronisers: plain shift chains, last stage is the usable level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_reset_i};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked_i};
    end
  end

  assign btn_s  = btn_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
  // differing samples; any agreement with the current level restarts the count.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (btn_s == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CNT_ONE;
    end
  end

  // Press counter counts accepted 0->1 edges of the debounced button and sticks at 255.
  always_comb begin
    press_cnt_d = press_cnt_q;
    if (btn_db_d && !btn_db_q && (press_cnt_q != 8'hFF)) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      press_cnt_q <= 8'd0;
    end else begin
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign ok = lock_s & ~btn_db_q;

  // FSM state register; the reset output flop is loaded from the next state so
  // rst_no changes on the same edge the FSM enters or leaves RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= WAIT;
      st_cnt_q <= '0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_cnt_q <= st_cnt_d;
      rst_n_q  <= (state_d == RUN);
    end
  end

  // Next-state logic. Losing ok anywhere returns to WAIT, so every release
  // goes through a complete stretch from zero.
  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    unique case (state_q)
      WAIT: begin
        if (ok) begin
          state_d  = STRETCH;
          st_cnt_d = '0;
        end
      end
      STRETCH: begin
        if (!ok) begin
          state_d = WAIT;
        end else if (st_cnt_q == ST_LAST) begin
          state_d = RUN;
        end else begin
          st_cnt_d = st_cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!ok) begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d  = WAIT;
        st_cnt_d = '0;
      end
    endcase
  end

  // Outputs are taken only from flops.
  always_comb begin
    rst_no       = rst_n_q;
    rst_active_o = ~rst_n_q;
    press_cnt_o  = press_cnt_q;
  end

endmodule
